// File: rtl/uart_pkg.sv
// Shared types and constants for the LED/button demo UART.
// Optional feature macro: UART_TX_EN (TX engine and banner ROM).
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Bit-level states of the serializer.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Message-level sequencing: HOLD waits for the button release so a held
  // button never repeats the banner.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_HOLD
  } seq_state_t;

  localparam int MSG_LEN = 12;

  // Banner "Lushay Labs ", first byte at index 0.
  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h4C; // L
      4'd1:    b = 8'h75; // u
      4'd2:    b = 8'h73; // s
      4'd3:    b = 8'h68; // h
      4'd4:    b = 8'h61; // a
      4'd5:    b = 8'h79; // y
      4'd6:    b = 8'h20; // space
      4'd7:    b = 8'h4C; // L
      4'd8:    b = 8'h61; // a
      4'd9:    b = 8'h62; // b
      4'd10:   b = 8'h73; // s
      4'd11:   b = 8'h20; // space
      default: b = 8'h20;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// 8N1 serializer. A byte is accepted on valid_i && ready_o. ready_o is also
// high in the last cycle of a stop bit so consecutive bytes go out with no
// idle gap.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);

  tx_state_t      state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     shreg_q;
  logic           tx_q;
  logic           stage_end;

  assign stage_end = (cnt_q == LAST);
  assign ready_o   = (state_q == TX_IDLE) || ((state_q == TX_STOP) && stage_end);
  assign tx_o      = tx_q;

  // Bit-timing FSM; the line level is registered so tx_o is glitch-free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else if (valid_i && ready_o) begin
      state_q <= TX_START;
      cnt_q   <= '0;
      shreg_q <= data_i;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: tx_q <= 1'b1;
        TX_START: begin
          if (stage_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= TX_DATA;
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (stage_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (stage_end) begin
            cnt_q   <= '0;
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_top.sv
// Board-level UART: 8N1 receiver driving active-low LEDs with the low six
// bits of the last good byte, and (with UART_TX_EN defined) a button that
// sends the "Lushay Labs " banner.
module uart_top
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [5:0] led,
  input  logic       btn
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] HALF = CW'(DELAY_FRAMES / 2 - 1);

  logic [1:0]    rx_sync_q;
  logic          rx_s;
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_byte_q;
  logic          rx_err_q;
  logic [5:0]    led_q;

  assign rx_s = rx_sync_q[1];
  assign led  = led_q;

  // Two-flop synchronizer on the asynchronous rx pin; idles high.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rx_sync_q <= 2'b11;
    else         rx_sync_q <= {rx_sync_q[0], uart_rx};
  end

  // Receiver: mid-bit sampling from the start edge; a low stop bit discards
  // the byte and parks in STOP until the line returns high.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
      rx_err_q   <= 1'b0;
      led_q      <= 6'h3F;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_q  <= '0;
            rx_byte_q <= {rx_s, rx_byte_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_err_q) begin
            if (rx_s) begin
              rx_err_q   <= 1'b0;
              rx_state_q <= RX_IDLE;
            end
          end else if (rx_cnt_q == LAST) begin
            rx_cnt_q <= '0;
            if (rx_s) begin
              led_q      <= ~rx_byte_q[5:0];
              rx_state_q <= RX_IDLE;
            end else begin
              rx_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_TX_EN
  logic [1:0] btn_sync_q;
  logic       btn_s;
  seq_state_t seq_q;
  logic [3:0] idx_q;
  logic       tx_valid;
  logic       tx_ready;

  assign btn_s    = btn_sync_q[1];
  assign tx_valid = (seq_q == SEQ_SEND);

  // Two-flop synchronizer on the button; released (1) at reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) btn_sync_q <= 2'b11;
    else         btn_sync_q <= {btn_sync_q[0], btn};
  end

  // Message sequencer: offer bytes back-to-back, then wait for release.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seq_q <= SEQ_IDLE;
      idx_q <= '0;
    end else begin
      case (seq_q)
        SEQ_IDLE: begin
          if (!btn_s) begin
            seq_q <= SEQ_SEND;
            idx_q <= '0;
          end
        end
        SEQ_SEND: begin
          if (tx_ready) begin
            if (idx_q == 4'(MSG_LEN - 1)) seq_q <= SEQ_HOLD;
            else                          idx_q <= idx_q + 1'b1;
          end
        end
        SEQ_HOLD: if (btn_s) seq_q <= SEQ_IDLE;
        default:  seq_q <= SEQ_IDLE;
      endcase
    end
  end

  uart_tx_engine #(.DELAY_FRAMES(DELAY_FRAMES)) u_tx (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .data_i  (msg_byte(idx_q)),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .tx_o    (uart_tx)
  );
`else
  logic unused_btn;
  assign unused_btn = btn;
  assign uart_tx    = 1'b1;
`endif

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top with DELAY_FRAMES = 8. A background monitor checks led
// and the idle tx line every cycle; TX frames are checked bit-by-bit against
// the banner text when UART_TX_EN is defined.
module tb_uart_top;
  localparam int D = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       btn     = 1'b1;
  logic       uart_tx;
  logic [5:0] led;

  int         n_chk   = 0;
  int         n_fail  = 0;
  logic [5:0] exp_led = 6'h3F;
  bit         led_skip = 1'b0;
  bit         tx_quiet = 1'b1;
  string      banner  = "Lushay Labs ";

  always #5 sys_clk = ~sys_clk;

  uart_top #(.DELAY_FRAMES(D)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .led     (led),
    .btn     (btn)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Per-cycle comparison against the model state.
  task automatic monitor();
    forever begin
      @(negedge sys_clk);
      if (!led_skip) check("led", {26'd0, led}, {26'd0, exp_led});
      if (tx_quiet)  check("tx_idle", {31'd0, uart_tx}, 32'd1);
    end
  endtask

  // Drive one 8N1 frame; a good frame updates the model at the end of its
  // stop bit, the DUT may update anywhere inside the stop bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    step(D);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      step(D);
    end
    uart_rx = stop_ok;
    if (stop_ok) led_skip = 1'b1;
    step(D);
    if (stop_ok) begin
      exp_led  = ~b[5:0];
      led_skip = 1'b0;
    end
    uart_rx = 1'b1;
    step(2 * D);
  endtask

`ifdef UART_TX_EN
  // Expected tx level at cycle i of the banner (frames back-to-back).
  function automatic logic banner_bit(input int i);
    int f, p;
    logic [7:0] c;
    f = i / (10 * D);
    p = (i % (10 * D)) / D;
    c = banner[f];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return c[p-1];
  endfunction

  task automatic check_msg();
    bit found;
    logic [7:0] first_b, last_b;
    found   = 1'b0;
    first_b = '0;
    last_b  = '0;
    for (int w = 0; w < 300 && !found; w++) begin
      @(negedge sys_clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check("tx_start_seen", {31'd0, found}, 32'd1);
    if (found) begin
      for (int i = 0; i < 12 * 10 * D; i++) begin
        int f, p;
        if (i > 0) @(negedge sys_clk);
        check("tx_bit", {31'd0, uart_tx}, {31'd0, banner_bit(i)});
        f = i / (10 * D);
        p = (i % (10 * D)) / D;
        if ((i % D) == D / 2 && p >= 1 && p <= 8) begin
          if (f == 0)  first_b[p-1] = uart_tx;
          if (f == 11) last_b[p-1]  = uart_tx;
        end
      end
      check("tx_first_byte", {24'd0, first_b}, 32'h4C);
      check("tx_last_byte", {24'd0, last_b}, 32'h20);
    end
    tx_quiet = 1'b1;
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none

    step(3);
    sys_rst = 1'b0;
    check("reset_led", {26'd0, led}, 32'h3F);
    check("reset_tx", {31'd0, uart_tx}, 32'd1);
    step(50);

    send_byte(8'h61, 1'b1);
    check("led_0x61", {26'd0, led}, 32'b011110);

    // Short glitch: false start, nothing changes.
    uart_rx = 1'b0;
    step(2);
    uart_rx = 1'b1;
    step(3 * D);
    check("led_false_start", {26'd0, led}, 32'b011110);

    send_byte(8'h3F, 1'b0);
    check("led_frame_err", {26'd0, led}, 32'b011110);
    send_byte(8'h05, 1'b1);
    check("led_0x05", {26'd0, led}, 32'b111010);

`ifdef UART_TX_EN
    tx_quiet = 1'b0;
    btn = 1'b0;
    check_msg();
    step(200);
    btn = 1'b1;
    step(20);
    tx_quiet = 1'b0;
    btn = 1'b0;
    check_msg();
    btn = 1'b1;
    step(20);
`else
    btn = 1'b0;
    step(200);
    btn = 1'b1;
    step(20);
`endif

    // Reset in the middle of an RX frame and a TX frame.
    tx_quiet = 1'b0;
    btn      = 1'b0;
    uart_rx  = 1'b0;
    step(30);
    sys_rst  = 1'b1;
    btn      = 1'b1;
    uart_rx  = 1'b1;
    exp_led  = 6'h3F;
    tx_quiet = 1'b1;
    #1;
    check("rst_mid_led", {26'd0, led}, 32'h3F);
    check("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
    step(3);
    sys_rst = 1'b0;
    step(10);
    send_byte(8'h61, 1'b1);
    check("led_after_rst", {26'd0, led}, 32'b011110);
    send_byte(8'hAA, 1'b1);
    check("led_0xAA", {26'd0, led}, 32'b010101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
